// File: rtl/sm4_pkg.sv
// Shared SM4 host-controller types and constants.
// FSM state encoding, block width and key-expansion timeout default.
package sm4_pkg;

  localparam int BLK_W           = 128;
  localparam int KEY_W           = 128;
  localparam int KEY_TIMEOUT_DEF = 64;
  localparam int CNT_W           = 32;

  typedef logic [BLK_W-1:0] blk_t;
  typedef logic [KEY_W-1:0] key_t;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_KEYEXP = 3'd1,
    ST_READY  = 3'd2,
    ST_BUSY   = 3'd3,
    ST_HOLD   = 3'd4
  } state_e;

  function automatic logic accepts_cfg(input state_e st);
    return (st == ST_IDLE) || (st == ST_READY);
  endfunction

endpackage

// File: rtl/sm4_host_ctrl_if.sv
// Block streams between the host and the SM4 controller.
// master = host side, slave = controller side.
interface sm4_host_ctrl_if;
  import sm4_pkg::*;

  blk_t s_data;
  logic s_valid;
  logic s_ready;
  blk_t m_data;
  logic m_valid;
  logic m_ready;

  modport master (
    output s_data,
    output s_valid,
    input  s_ready,
    input  m_data,
    input  m_valid,
    output m_ready
  );

  modport slave (
    input  s_data,
    input  s_valid,
    output s_ready,
    output m_data,
    output m_valid,
    input  m_ready
  );

endinterface

// File: rtl/sm4_out_buf.sv
// One-entry valid/ready result register.
// A write is only taken while empty; a read handshake empties it.
module sm4_out_buf
  import sm4_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic wr_i,
  input  blk_t wr_data_i,
  output logic valid_o,
  output blk_t data_o,
  input  logic ready_i,
  output logic empty_o
);

  logic valid_q;
  logic valid_d;
  blk_t data_q;
  blk_t data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
    if (wr_i && !valid_q) begin
      valid_d = 1'b1;
      data_d  = wr_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign empty_o = !valid_q;

endmodule

// File: rtl/sm4_host_ctrl.sv
// Host-side sequencer for an sm4_core: key load, one block in flight,
// result held in a 1-entry buffer until the host takes it.
module sm4_host_ctrl
  import sm4_pkg::*;
#(
  parameter int KEY_TIMEOUT = KEY_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,

  input  key_t cfg_key,
  input  logic cfg_encdec,
  input  logic cfg_start,
  output logic key_ready,
  output logic key_err,

  sm4_host_ctrl_if.slave bus,

  output cnt_t blk_cnt,

  output logic core_en_sm4,
  output logic core_encdec,
  output logic core_en_key_exps,
  output logic core_key_valid,
  output logic core_bdi_valid,
  output key_t core_key,
  output blk_t core_bdi,
  input  logic core_key_exps_done,
  input  logic core_bdo_valid,
  input  blk_t core_bdo
);

  localparam int TW = $clog2(KEY_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(KEY_TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  key_t          key_q, key_d;
  logic          encdec_q, encdec_d;
  logic          en_sm4_q, en_sm4_d;
  logic          kexp_q, kexp_d;
  logic          kvalid_q, kvalid_d;
  blk_t          bdi_q, bdi_d;
  logic          bdi_vld_q, bdi_vld_d;
  logic          kready_q, kready_d;
  logic          kerr_q, kerr_d;
  cnt_t          cnt_q, cnt_d;

  logic buf_wr;
  logic buf_valid;
  logic buf_empty;
  blk_t buf_data;
  logic start;
  logic s_hs;
  logic m_hs;

  // cfg_start in READY takes priority, so s_ready is withheld that cycle
  assign start = cfg_start && accepts_cfg(state_q);

  assign bus.s_ready = !rst && (state_q == ST_READY)
                       && buf_empty && !cfg_start;
  assign bus.m_valid = buf_valid;
  assign bus.m_data  = buf_data;

  assign s_hs = bus.s_valid && bus.s_ready;
  assign m_hs = buf_valid && bus.m_ready;

  sm4_out_buf u_out_buf (
    .clk       (clk),
    .rst       (rst),
    .wr_i      (buf_wr),
    .wr_data_i (core_bdo),
    .valid_o   (buf_valid),
    .data_o    (buf_data),
    .ready_i   (bus.m_ready),
    .empty_o   (buf_empty)
  );

  always_comb begin
    state_d   = state_q;
    tmo_d     = tmo_q;
    key_d     = key_q;
    encdec_d  = encdec_q;
    en_sm4_d  = en_sm4_q;
    kexp_d    = kexp_q;
    kvalid_d  = kvalid_q;
    bdi_d     = bdi_q;
    bdi_vld_d = bdi_vld_q;
    kready_d  = kready_q;
    kerr_d    = kerr_q;
    cnt_d     = cnt_q;
    buf_wr    = 1'b0;

    if (start) begin
      state_d  = ST_KEYEXP;
      tmo_d    = '0;
      key_d    = cfg_key;
      encdec_d = cfg_encdec;
      en_sm4_d = 1'b1;
      kexp_d   = 1'b1;
      kvalid_d = 1'b1;
      kready_d = 1'b0;
      kerr_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
        end
        ST_KEYEXP: begin
          if (core_key_exps_done) begin
            state_d  = ST_READY;
            kexp_d   = 1'b0;
            kvalid_d = 1'b0;
            kready_d = 1'b1;
            kerr_d   = 1'b0;
          end else if (tmo_q == TO_LAST) begin
            // give up and park the core fully disabled
            state_d  = ST_IDLE;
            tmo_d    = '0;
            encdec_d = 1'b0;
            en_sm4_d = 1'b0;
            kexp_d   = 1'b0;
            kvalid_d = 1'b0;
            kready_d = 1'b0;
            kerr_d   = 1'b1;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
        ST_READY: begin
          if (s_hs) begin
            state_d   = ST_BUSY;
            bdi_d     = bus.s_data;
            bdi_vld_d = 1'b1;
          end
        end
        ST_BUSY: begin
          if (core_bdo_valid) begin
            state_d   = ST_HOLD;
            bdi_vld_d = 1'b0;
            buf_wr    = 1'b1;
          end
        end
        ST_HOLD: begin
          if (m_hs) begin
            state_d = ST_READY;
            cnt_d   = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      tmo_q     <= '0;
      key_q     <= '0;
      encdec_q  <= 1'b0;
      en_sm4_q  <= 1'b0;
      kexp_q    <= 1'b0;
      kvalid_q  <= 1'b0;
      bdi_q     <= '0;
      bdi_vld_q <= 1'b0;
      kready_q  <= 1'b0;
      kerr_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      key_q     <= key_d;
      encdec_q  <= encdec_d;
      en_sm4_q  <= en_sm4_d;
      kexp_q    <= kexp_d;
      kvalid_q  <= kvalid_d;
      bdi_q     <= bdi_d;
      bdi_vld_q <= bdi_vld_d;
      kready_q  <= kready_d;
      kerr_q    <= kerr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign key_ready        = kready_q;
  assign key_err          = kerr_q;
  assign blk_cnt          = cnt_q;
  assign core_en_sm4      = en_sm4_q;
  assign core_encdec      = encdec_q;
  assign core_en_key_exps = kexp_q;
  assign core_key_valid   = kvalid_q;
  assign core_bdi_valid   = bdi_vld_q;
  assign core_key         = key_q;
  assign core_bdi         = bdi_q;

endmodule
